// File: rtl/sdc_dat_pkg.sv
// Shared types and constants for the card-side SD DAT line engine.
// FSM encoding, CRC16 polynomial and CRC status token patterns.
package sdc_dat_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_NAC,
    RD_DATA,
    RD_CRC,
    RD_END,
    WR_DATA,
    WR_CRC,
    WR_END,
    WR_NCRC,
    WR_TOK,
    WR_BUSY
  } dat_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [2:0]  TOK_OK     = 3'b010;
  localparam logic [2:0]  TOK_ERR    = 3'b101;

endpackage

// File: rtl/sd_crc16_ser.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), MSB first, zero init.
// Shared by the read and write paths of the DAT engine.
module sd_crc16_ser
  import sdc_dat_pkg::*;
(
  input  logic        sd_clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[15];

  always_ff @(posedge sd_clk) begin
    if (reset || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sdc_dat_card_mod.sv
// Card-side 1-bit SD DAT engine: sends read blocks, receives write
// blocks, answers with CRC status token and busy.
module sdc_dat_card_mod
  import sdc_dat_pkg::*;
#(
  parameter int BLK_BYTES = 512,
  parameter int NAC_CYC   = 2,
  parameter int NCRC_CYC  = 2,
  parameter int BUSY_CYC  = 8
) (
  input  logic       sd_clk,
  input  logic       reset,
  input  logic       dat_in,
  output logic       dat_out,
  output logic       dat_oe,
  input  logic       rd_blk_strb,
  input  logic [7:0] rd_byte,
  output logic       rd_byte_req,
  output logic       rd_done_strb,
  output logic [7:0] wr_byte,
  output logic       wr_byte_vld,
  output logic       wr_crc_ok,
  output logic       wr_done_strb,
  output logic       busy
);

  localparam int NBITS = BLK_BYTES * 8;
  localparam int CLOG  = $clog2(NBITS);
  localparam int CW    = (CLOG < 5) ? 5 : CLOG;

  localparam logic [CW-1:0] NAC_LAST  = CW'(NAC_CYC);
  localparam logic [CW-1:0] DATA_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] REQ_LIM   = CW'(NBITS - 8);
  localparam logic [CW-1:0] CRC_LAST  = CW'(15);
  localparam logic [CW-1:0] NCRC_LAST = CW'(NCRC_CYC - 1);
  localparam logic [CW-1:0] TOK_LAST  = CW'(4);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_CYC);

  dat_state_e    state;
  dat_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic          dat_in_z1;
  logic          start_det;
  logic [7:0]    tx_sr;
  logic [6:0]    rx_sr;
  logic [15:0]   rx_crc;
  logic [15:0]   crc;
  logic          crc_clr;
  logic          crc_en;
  logic          crc_bit;
  logic [2:0]    tok;

  assign start_det = !dat_in && dat_in_z1;
  assign busy      = (state != IDLE);
  assign tok       = wr_crc_ok ? TOK_OK : TOK_ERR;

  // Counter restarts on every state change, so it never wraps.
  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || state_nxt != state) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_blk_strb) begin
          state_nxt = RD_NAC;
        end else if (start_det) begin
          state_nxt = WR_DATA;
        end
      end
      RD_NAC:  if (cnt == NAC_LAST)  state_nxt = RD_DATA;
      RD_DATA: if (cnt == DATA_LAST) state_nxt = RD_CRC;
      RD_CRC:  if (cnt == CRC_LAST)  state_nxt = RD_END;
      RD_END:  state_nxt = IDLE;
      WR_DATA: if (cnt == DATA_LAST) state_nxt = WR_CRC;
      WR_CRC:  if (cnt == CRC_LAST)  state_nxt = WR_END;
      WR_END:  state_nxt = WR_NCRC;
      WR_NCRC: if (cnt == NCRC_LAST) state_nxt = WR_TOK;
      WR_TOK:  if (cnt == TOK_LAST)  state_nxt = WR_BUSY;
      WR_BUSY: if (cnt == BUSY_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Last NAC cycle carries the start bit.
  always_comb begin
    dat_out     = 1'b1;
    dat_oe      = 1'b0;
    rd_byte_req = 1'b0;
    case (state)
      RD_NAC: begin
        rd_byte_req = (cnt == '0);
        if (cnt == NAC_LAST) begin
          dat_oe  = 1'b1;
          dat_out = 1'b0;
        end
      end
      RD_DATA: begin
        dat_oe      = 1'b1;
        dat_out     = tx_sr[7];
        rd_byte_req = (cnt[2:0] == 3'd1) && (cnt < REQ_LIM);
      end
      RD_CRC: begin
        dat_oe  = 1'b1;
        dat_out = crc[~cnt[3:0]];
      end
      RD_END: begin
        dat_oe  = 1'b1;
        dat_out = 1'b1;
      end
      WR_TOK: begin
        dat_oe = 1'b1;
        case (cnt[2:0])
          3'd0:    dat_out = 1'b0;
          3'd1:    dat_out = tok[2];
          3'd2:    dat_out = tok[1];
          3'd3:    dat_out = tok[0];
          default: dat_out = 1'b1;
        endcase
      end
      WR_BUSY: begin
        dat_oe  = 1'b1;
        dat_out = (cnt == BUSY_LAST);
      end
      default: begin
        dat_out = 1'b1;
      end
    endcase
  end

  assign crc_clr = (state == IDLE) && (state_nxt != IDLE);
  assign crc_en  = (state == RD_DATA) || (state == WR_DATA);
  assign crc_bit = (state == RD_DATA) ? tx_sr[7] : dat_in;

  sd_crc16_ser u_crc (
    .sd_clk (sd_clk),
    .reset  (reset),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      dat_in_z1    <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      rx_crc       <= '0;
      wr_byte      <= '0;
      wr_byte_vld  <= 1'b0;
      wr_crc_ok    <= 1'b0;
      rd_done_strb <= 1'b0;
      wr_done_strb <= 1'b0;
    end else begin
      dat_in_z1    <= dat_in;
      wr_byte_vld  <= 1'b0;
      rd_done_strb <= (state == RD_END);
      wr_done_strb <= (state == WR_BUSY) && (cnt == BUSY_LAST);
      case (state)
        RD_NAC: begin
          if (cnt == NAC_LAST) tx_sr <= rd_byte;
        end
        RD_DATA: begin
          if (cnt[2:0] == 3'd7) begin
            tx_sr <= rd_byte;
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
        WR_DATA: begin
          rx_sr <= {rx_sr[5:0], dat_in};
          if (cnt[2:0] == 3'd7) begin
            wr_byte     <= {rx_sr, dat_in};
            wr_byte_vld <= 1'b1;
          end
        end
        WR_CRC: begin
          rx_crc <= {rx_crc[14:0], dat_in};
        end
        WR_END: begin
          wr_crc_ok <= (rx_crc == crc) && dat_in;
        end
        default: begin
          tx_sr <= tx_sr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_dat_card_mod.sv
// Directed bench for sdc_dat_card_mod: read and write blocks,
// CRC error tokens, strobe priority and reset mid-read.
module tb_sdc_dat_card_mod;

  logic       sd_clk = 1'b0;
  logic       reset = 1'b1;
  logic       dat_in = 1'b1;
  logic       dat_out;
  logic       dat_oe;
  logic       rd_blk_strb = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  logic       rd_byte_req;
  logic       rd_done_strb;
  logic [7:0] wr_byte;
  logic       wr_byte_vld;
  logic       wr_crc_ok;
  logic       wr_done_strb;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int req_n = 0;
  int vld_n = 0;
  int bad_n = 0;
  int rdone_n = 0;
  int wdone_n = 0;

  sdc_dat_card_mod dut (
    .sd_clk       (sd_clk),
    .reset        (reset),
    .dat_in       (dat_in),
    .dat_out      (dat_out),
    .dat_oe       (dat_oe),
    .rd_blk_strb  (rd_blk_strb),
    .rd_byte      (rd_byte),
    .rd_byte_req  (rd_byte_req),
    .rd_done_strb (rd_done_strb),
    .wr_byte      (wr_byte),
    .wr_byte_vld  (wr_byte_vld),
    .wr_crc_ok    (wr_crc_ok),
    .wr_done_strb (wr_done_strb),
    .busy         (busy)
  );

  always #5 sd_clk = ~sd_clk;

  always @(negedge sd_clk) begin
    if (rd_byte_req) req_n++;
    if (rd_done_strb) rdone_n++;
    if (wr_done_strb) wdone_n++;
    if (wr_byte_vld) begin
      vld_n++;
      if (wr_byte !== 8'hFF) bad_n++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_read(input logic [7:0]  val,
                          input logic [15:0] exp_crc,
                          input bit          coincide);
    int oe_n, first_oe, done_c, bad, pos;
    int q0, v0, d0;
    logic [15:0] crcf;
    logic start_b, end_b;
    oe_n = 0; first_oe = -1; done_c = -1; bad = 0;
    crcf = '0; start_b = 1'b1; end_b = 1'b0;
    q0 = req_n; v0 = vld_n; d0 = rdone_n;
    @(negedge sd_clk);
    rd_byte = val;
    rd_blk_strb = 1'b1;
    if (coincide) dat_in = 1'b0;
    @(negedge sd_clk);
    rd_blk_strb = 1'b0;
    dat_in = 1'b1;
    for (int c = 1; c <= 4200 && done_c < 0; c++) begin
      if (rd_done_strb) begin
        done_c = c;
      end else begin
        if (dat_oe) begin
          if (first_oe < 0) first_oe = c;
          pos = c - first_oe;
          oe_n++;
          if (pos == 0) begin
            start_b = dat_out;
          end else if (pos <= 4096) begin
            if (dat_out !== val[7 - ((pos - 1) % 8)]) bad++;
          end else if (pos <= 4112) begin
            crcf = {crcf[14:0], dat_out};
          end else begin
            end_b = dat_out;
          end
        end
        @(negedge sd_clk);
      end
    end
    chk("rd_start_cycle", first_oe, 3);
    chk("rd_start_bit", start_b, 0);
    chk("rd_data_bits_bad", bad, 0);
    chk("rd_crc_field", crcf, exp_crc);
    chk("rd_end_bit", end_b, 1);
    chk("rd_oe_cycles", oe_n, 4114);
    chk("rd_done_cycle", done_c, 4117);
    chk("rd_done_oe", dat_oe, 0);
    chk("rd_done_busy", busy, 0);
    @(negedge sd_clk);
    chk("rd_done_once", rd_done_strb, 0);
    chk("rd_done_count", rdone_n - d0, 1);
    chk("rd_req_count", req_n - q0, 512);
    chk("rd_no_wr_bytes", vld_n - v0, 0);
  endtask

  task automatic run_write(input logic [15:0] crcv,
                           input logic        endb,
                           input logic [4:0]  exp_line,
                           input logic        exp_ok,
                           input bit          mid_strobe);
    int first_oe, low_n, hi_p, done_c, p;
    int q0, v0, b0, w0;
    logic [4:0] tokv;
    first_oe = -1; low_n = 0; hi_p = -1; done_c = -1;
    tokv = '0;
    q0 = req_n; v0 = vld_n; b0 = bad_n; w0 = wdone_n;
    @(negedge sd_clk);
    dat_in = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge sd_clk);
      dat_in = 1'b1;
      rd_blk_strb = mid_strobe && (i == 100);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge sd_clk);
      dat_in = crcv[15 - i];
    end
    @(negedge sd_clk);
    dat_in = endb;
    @(negedge sd_clk);
    dat_in = 1'b1;
    chk("wr_crc_ok", wr_crc_ok, exp_ok);
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      if (wr_done_strb) begin
        done_c = c;
      end else begin
        if (dat_oe) begin
          if (first_oe < 0) first_oe = c;
          p = c - first_oe;
          if (p < 5) tokv[4 - p] = dat_out;
          else if (dat_out === 1'b0) low_n++;
          else hi_p = p;
        end
        @(negedge sd_clk);
      end
    end
    chk("wr_tok_cycle", first_oe, 3);
    chk("wr_tok_bits", tokv, exp_line);
    chk("wr_busy_low", low_n, 8);
    chk("wr_busy_high_pos", hi_p, 13);
    chk("wr_done_cycle", done_c, 17);
    chk("wr_done_oe", dat_oe, 0);
    chk("wr_done_busy", busy, 0);
    @(negedge sd_clk);
    chk("wr_done_count", wdone_n - w0, 1);
    chk("wr_vld_count", vld_n - v0, 512);
    chk("wr_byte_bad", bad_n - b0, 0);
    chk("wr_no_rd_req", req_n - q0, 0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge sd_clk);
    chk("rst_dat_out", dat_out, 1);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", rd_byte_req, 0);
    chk("rst_rd_done", rd_done_strb, 0);
    chk("rst_wr_byte", wr_byte, 8'h00);
    chk("rst_wr_vld", wr_byte_vld, 0);
    chk("rst_crc_ok", wr_crc_ok, 0);
    chk("rst_wr_done", wr_done_strb, 0);
    reset = 1'b0;
    repeat (2) @(negedge sd_clk);

    run_read(8'h00, 16'h0000, 1'b0);
    run_read(8'hFF, 16'h7FA1, 1'b0);

    run_write(16'h7FA1, 1'b1, 5'b00101, 1'b1, 1'b0);
    run_write(16'h7FA0, 1'b1, 5'b01011, 1'b0, 1'b0);
    run_write(16'h7FA1, 1'b0, 5'b01011, 1'b0, 1'b0);

    run_read(8'hFF, 16'h7FA1, 1'b1);
    run_write(16'h7FA1, 1'b1, 5'b00101, 1'b1, 1'b1);

    d0 = rdone_n;
    @(negedge sd_clk);
    rd_byte = 8'h5A;
    rd_blk_strb = 1'b1;
    @(negedge sd_clk);
    rd_blk_strb = 1'b0;
    repeat (806) @(negedge sd_clk);
    chk("mid_read_oe", dat_oe, 1);
    reset = 1'b1;
    @(negedge sd_clk);
    chk("mid_rst_oe", dat_oe, 0);
    chk("mid_rst_out", dat_out, 1);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    repeat (20) @(negedge sd_clk);
    chk("mid_rst_no_done", rdone_n - d0, 0);

    run_read(8'hFF, 16'h7FA1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
